// File: rtl/boxcar_decimator.sv
// boxcar_decimator
//   Accumulate-and-dump decimator behind the phasemeter mixer. Sums n_act
//   consecutive valid samples, scales the sum by an arithmetic right shift,
//   saturates it to OUTPUT_WIDTH and presents it on an AXI4-Stream master.
//
// Ports
//   clk            clock
//   rst            asynchronous active-low reset
//   MIXED_AB       signed mixer product
//   in_valid       MIXED_AB carries a sample this cycle (always accepted)
//   DECIM          decimation ratio, 0 treated as 1, latched at each dump
//   SHIFT          arithmetic right shift applied to each dump
//   m_axis_tdata   decimated signed result
//   m_axis_tvalid  result available
//   m_axis_tready  downstream accepts
//   OVERRUN        sticky: a dump was discarded because the output was held
//   SATURATED      sticky: a result was clipped
module boxcar_decimator #(
    parameter int INPUT_WIDTH  = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int ACCUM_WIDTH  = 48,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  MIXED_AB,
    input  logic                    in_valid,
    input  logic [CNT_WIDTH-1:0]    DECIM,
    input  logic [5:0]              SHIFT,
    output logic [OUTPUT_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    OVERRUN,
    output logic                    SATURATED
);

    logic signed [ACCUM_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]          n_act_q, n_act_d;
    logic [OUTPUT_WIDTH-1:0]       tdata_q, tdata_d;
    logic                          tvalid_q, tvalid_d;
    logic                          overrun_q, overrun_d;
    logic                          sat_q, sat_d;

    logic signed [ACCUM_WIDTH-1:0] sample_ext;
    logic signed [ACCUM_WIDTH-1:0] sum;
    logic signed [ACCUM_WIDTH-1:0] scaled;
    logic [ACCUM_WIDTH-OUTPUT_WIDTH:0] upper;
    logic                          clip;
    logic [OUTPUT_WIDTH-1:0]       result;
    logic                          dump;

    always_comb begin
        sample_ext = {{(ACCUM_WIDTH-INPUT_WIDTH){MIXED_AB[INPUT_WIDTH-1]}}, MIXED_AB};
        sum        = acc_q + sample_ext;
        dump       = in_valid && (cnt_q == n_act_q - CNT_WIDTH'(1));

        // Shifts beyond the accumulator width collapse to pure sign fill.
        if (32'(SHIFT) >= ACCUM_WIDTH) begin
            scaled = {ACCUM_WIDTH{sum[ACCUM_WIDTH-1]}};
        end else begin
            scaled = sum >>> SHIFT;
        end

        // The value fits in OUTPUT_WIDTH only if every bit from the output
        // sign bit upward is a copy of the accumulator sign.
        upper = scaled[ACCUM_WIDTH-1:OUTPUT_WIDTH-1];
        clip  = !((&upper) || !(|upper));
        if (!clip) begin
            result = scaled[OUTPUT_WIDTH-1:0];
        end else if (scaled[ACCUM_WIDTH-1]) begin
            result = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end else begin
            result = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        n_act_d   = n_act_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        overrun_d = overrun_q;
        sat_d     = sat_q;

        if (in_valid) begin
            if (dump) begin
                acc_d   = '0;
                cnt_d   = '0;
                n_act_d = (DECIM == '0) ? CNT_WIDTH'(1) : DECIM;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (dump) begin
            if (clip) begin
                sat_d = 1'b1;
            end
            // A word being accepted this edge frees the register for the dump.
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = result;
                tvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            n_act_q   <= CNT_WIDTH'(1);
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            n_act_q   <= n_act_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign OVERRUN       = overrun_q;
    assign SATURATED     = sat_q;

endmodule

// File: tb/tb_boxcar_decimator.sv
module tb_boxcar_decimator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] MIXED_AB;
    logic               in_valid;
    logic [15:0]        DECIM;
    logic [5:0]         SHIFT;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               OVERRUN;
    logic               SATURATED;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Behavioural model: the current frame is a list of samples.
    int          frame[$];
    int          m_n;
    logic [31:0] exp_tdata;
    logic        exp_tvalid;
    logic        exp_ovr;
    logic        exp_sat;

    boxcar_decimator #(
        .INPUT_WIDTH (32),
        .CNT_WIDTH   (16),
        .ACCUM_WIDTH (48),
        .OUTPUT_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MIXED_AB     (MIXED_AB),
        .in_valid     (in_valid),
        .DECIM        (DECIM),
        .SHIFT        (SHIFT),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .OVERRUN      (OVERRUN),
        .SATURATED    (SATURATED)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame.delete();
        m_n        = 1;
        exp_tdata  = '0;
        exp_tvalid = 1'b0;
        exp_ovr    = 1'b0;
        exp_sat    = 1'b0;
    endtask

    // Applied at every rising edge with the inputs present at that edge.
    task automatic model_step();
        longint sum;
        longint r;
        bit     dump;
        bit     old_v;
        dump  = 1'b0;
        sum   = 0;
        old_v = exp_tvalid;
        if (in_valid) begin
            frame.push_back(MIXED_AB);
            if (frame.size() == m_n) begin
                dump = 1'b1;
                foreach (frame[i]) sum += longint'(frame[i]);
                frame.delete();
                m_n = (DECIM == 0) ? 1 : int'(DECIM);
            end
        end
        if (old_v && m_axis_tready) exp_tvalid = 1'b0;
        if (dump) begin
            r = sum >>> SHIFT;
            if (r > 64'sd2147483647) begin
                r = 64'sd2147483647;
                exp_sat = 1'b1;
            end else if (r < -64'sd2147483648) begin
                r = -64'sd2147483648;
                exp_sat = 1'b1;
            end
            if (!old_v || m_axis_tready) begin
                exp_tdata  = r[31:0];
                exp_tvalid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Checks a DUT output and the model against a hand-computed value.
    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] lit);
        chk({name, "_dut"}, 64'(act), 64'(lit));
        chk({name, "_model"}, 64'(mdl), 64'(lit));
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("tvalid", 64'(m_axis_tvalid), 64'(exp_tvalid));
            chk("tdata", 64'(m_axis_tdata), 64'(exp_tdata));
            chk("overrun", 64'(OVERRUN), 64'(exp_ovr));
            chk("saturated", 64'(SATURATED), 64'(exp_sat));
        end
    end

    initial begin
        rst           = 1'b0;
        MIXED_AB      = '0;
        in_valid      = 1'b0;
        DECIM         = 16'd4;
        SHIFT         = 6'd0;
        m_axis_tready = 1'b1;
        model_reset();
        @(negedge clk);
        pin("rst_tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd0);
        pin("rst_tdata", m_axis_tdata, exp_tdata, 32'd0);
        pin("rst_flags", {30'd0, OVERRUN, SATURATED}, {30'd0, exp_ovr, exp_sat}, 32'd0);
        rst      = 1'b1;
        check_en = 1'b1;

        // Constant 1000, N=4: reset-exit frame of one sample, then 4000 every 4.
        MIXED_AB = 32'sd1000;
        in_valid = 1'b1;
        tick();
        pin("first_frame", m_axis_tdata, exp_tdata, 32'd1000);
        ticks(3);
        pin("mid_frame_tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd0);
        tick();
        pin("sum4", m_axis_tdata, exp_tdata, 32'd4000);
        pin("sum4_tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd1);
        tick();
        pin("pulse_drop", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd0);
        ticks(3);

        // SHIFT=2 scales 4000 down to 1000.
        SHIFT = 6'd2;
        ticks(4);
        pin("shift2", m_axis_tdata, exp_tdata, 32'd1000);
        pin("no_sat", 32'(SATURATED), 32'(exp_sat), 32'd0);

        // Saturation at both rails.
        SHIFT    = 6'd0;
        MIXED_AB = 32'sh8000_0000;
        ticks(4);
        pin("sat_neg", m_axis_tdata, exp_tdata, 32'h8000_0000);
        pin("sat_flag", 32'(SATURATED), 32'(exp_sat), 32'd1);
        MIXED_AB = 32'sh7FFF_FFFF;
        ticks(4);
        pin("sat_pos", m_axis_tdata, exp_tdata, 32'h7FFF_FFFF);

        // Backpressure: first dump held, later dumps dropped.
        in_valid = 1'b0;
        tick();
        MIXED_AB      = 32'sd1000;
        in_valid      = 1'b1;
        m_axis_tready = 1'b0;
        ticks(12);
        pin("held_word", m_axis_tdata, exp_tdata, 32'd4000);
        pin("held_valid", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd1);
        pin("overrun", 32'(OVERRUN), 32'(exp_ovr), 32'd1);
        m_axis_tready = 1'b1;
        in_valid      = 1'b0;
        tick();
        pin("drain", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd0);

        // DECIM change mid-frame takes effect on the next frame.
        MIXED_AB = 32'sd100;
        in_valid = 1'b1;
        ticks(2);
        DECIM = 16'd2;
        ticks(2);
        pin("decim_old_frame", m_axis_tdata, exp_tdata, 32'd400);
        ticks(2);
        pin("decim_new_frame", m_axis_tdata, exp_tdata, 32'd200);
        DECIM = 16'd0;
        ticks(2);
        MIXED_AB = -32'sd7;
        tick();
        pin("decim0", m_axis_tdata, exp_tdata, 32'hFFFF_FFF9);
        MIXED_AB = 32'sd12345;
        tick();
        pin("decim0_b2b", m_axis_tdata, exp_tdata, 32'd12345);
        pin("decim0_valid", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd1);

        // Reset mid-frame discards the partial sum.
        DECIM = 16'd4;
        tick();
        MIXED_AB = 32'sd1000;
        ticks(3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        pin("rst_mid_tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid), 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        MIXED_AB = 32'sd50;
        tick();
        pin("after_rst", m_axis_tdata, exp_tdata, 32'd50);

        // Toggling in_valid: one output per 8 cycles.
        MIXED_AB = 32'sd25;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            if (i == 6) pin("sparse_out", m_axis_tdata, exp_tdata, 32'd100);
        end

        // Shift beyond accumulator width leaves only the sign.
        in_valid = 1'b1;
        SHIFT    = 6'd50;
        MIXED_AB = -32'sd5;
        ticks(4);
        pin("big_shift", m_axis_tdata, exp_tdata, 32'hFFFF_FFFF);
        ticks(2);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Accumulate-and-dump low-pass/decimation stage that sits directly downstream of the phasemeter mixer. It consumes the signed full-rate product stream from the mixer and sums N consecutive valid samples (boxcar filter). It emits one scaled, saturated result per N inputs on an AXI4-Stream master toward the phase-extraction/readout logic. The ratio N and the output scaling are runtime registers.

## Interface
Parameters:
- INPUT_WIDTH, 32, width of signed mixer product.
- CNT_WIDTH, 16, width of decimation ratio / sample counter.
- ACCUM_WIDTH, 48, accumulator width. Must be ≥ INPUT_WIDTH + CNT_WIDTH; the accumulator never wraps.
- OUTPUT_WIDTH, 32, width of signed output word.

Ports:
- clk  in  1  single clock domain for all logic.
- rst  in  1  asynchronous, active-low reset.
- MIXED_AB  in  INPUT_WIDTH  signed mixer product.
- in_valid  in  1  MIXED_AB carries a sample this cycle.
- DECIM  in  CNT_WIDTH  decimation ratio N. Value 0 is treated as 1.
- SHIFT  in  6  arithmetic right shift applied to each dump before saturation.
- m_axis_tdata  out  OUTPUT_WIDTH  decimated signed result.
- m_axis_tvalid  out  1  result available.
- m_axis_tready  in  1  downstream accepts.
- OVERRUN  out  1  sticky: a dump was dropped because the output register was occupied.
- SATURATED  out  1  sticky: a result was clipped.

## Operation
- Registers:
  - acc (ACCUM_WIDTH, signed).
  - cnt (CNT_WIDTH).
  - n_act (CNT_WIDTH), the active ratio.
  - Output register with valid bit.
  - Two sticky flags.
- Reset (rst low, asynchronous):
  - acc=0, cnt=0, n_act=1.
  - m_axis_tdata=0, m_axis_tvalid=0.
  - OVERRUN=0, SATURATED=0.
- Each cycle with in_valid=1, the sample is sign-extended to ACCUM_WIDTH.
  - If cnt ≠ n_act−1: acc ← acc+sample, cnt ← cnt+1.
  - If cnt = n_act−1 (dump):
    - sum = acc+sample.
    - acc ← 0, cnt ← 0.
    - n_act ← (DECIM==0 ? 1 : DECIM).
- DECIM is sampled only at a dump (and at reset exit, as 1). A change mid-frame affects the next frame only.
- Scaling: r = sum >>> SHIFT (arithmetic). SHIFT ≥ ACCUM_WIDTH yields 0 or −1 by sign.
- Saturation: if r > 2^(OUTPUT_WIDTH−1)−1 or r < −2^(OUTPUT_WIDTH−1), clip to that bound and set SATURATED.
- Output register / AXIS rules:
  - tvalid=1 with tready=1 at an edge transfers the word. With no new dump, tvalid ← 0.
  - tdata and tvalid do not change while tvalid=1 and tready=0, except when a same-cycle dump finds tready=1.
  - Dump while the register is empty, or while it is being accepted this cycle: load r, tvalid ← 1. A back-to-back transfer keeps tvalid high.
  - Dump while tvalid=1 and tready=0: the new result is discarded, the held word is preserved, and OVERRUN is set.
- in_valid=0 holds acc and cnt unchanged. There is no input backpressure; the input is always accepted.
- Sticky flags clear only on reset.

## Timing
- Latency: the dump sample is accepted at edge k. m_axis_tvalid and m_axis_tdata are updated at edge k (registered), so they are visible in the cycle after the dump sample is presented.
- Throughput: one result per n_act valid samples. With N=1, one result per valid cycle, sustainable only with tready held high.
- Reset asserted mid-frame: the partial sum is discarded immediately, and the next frame starts from sample 0 with N=1 until the first dump latches DECIM.
- Counter boundary: cnt never exceeds n_act−1, and its maximum is 2^CNT_WIDTH−2.

## Test plan
- MIXED_AB=1000 constant, in_valid=1, DECIM=4, SHIFT=0, tready=1 → after the reset-exit N=1 frame, tdata=4000 every 4th cycle. tvalid is a 1-cycle pulse.
- Same stimulus, SHIFT=2 → tdata=1000 every 4 cycles; SATURATED stays 0.
- MIXED_AB=−2^31 constant, DECIM=4, SHIFT=0 → tdata=0x80000000 and SATURATED=1. +2^31−1 gives 0x7FFFFFFF.
- DECIM=4 with tready=0 for 12 cycles → the first word (4000) is held unchanged and OVERRUN=1. When tready rises, 4000 transfers; tvalid drops unless a dump occurs the same cycle.
- DECIM switched 4→2 after the 2nd sample of a frame → the current frame still completes at 4 samples, and subsequent outputs come every 2 samples. DECIM=0 → every valid sample is output, with tdata=sample.
- rst pulsed low after 3 of 4 samples → tvalid=0, and the next frame sums from zero. in_valid toggling 1010… with DECIM=4 → one output per 8 cycles with value 4×sample.
